// File: rtl/bus_sram_slave.sv
// Femto-bus slave: word-organised SRAM/TCM with byte lanes and programmable wait states.
// Optional BUS_SRAM_MISALIGN_FAULT_EN faults misaligned half/word accesses instead of aligning them.
module bus_sram_slave #(
    parameter int SPAN        = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_req,
    input  logic [SPAN-1:0] s_addr,
    input  logic            s_w_rb,
    input  logic [1:0]      s_acc,
    input  logic [31:0]     s_wdata,
    output logic            s_resp,
    output logic [31:0]     s_rdata,
    output logic            s_fault
);

    localparam int DEPTH = 2 ** (SPAN - 2);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [SPAN-1:0] addr_q, addr_d;
    logic            w_rb_q, w_rb_d;
    logic [1:0]      acc_q, acc_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            resp_q, resp_d;
    logic            fault_q, fault_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            commit;

    logic [31:0]     mem [DEPTH];

    logic [SPAN-1:0] a_addr;
    logic            a_w_rb;
    logic [1:0]      a_acc;
    logic [31:0]     a_wdata;
    logic [1:0]      lane;
    logic [1:0]      eff_lane;
    logic            mis;
    logic            acc_fault;
    logic [3:0]      be;
    logic [31:0]     wd_shift;
    logic [31:0]     rd_shift;
    logic [31:0]     rd_val;
    logic            we;

    // With zero wait states the commit edge is the request edge itself.
    always_comb begin
        if (state_q == ST_IDLE) begin
            a_addr  = s_addr;
            a_w_rb  = s_w_rb;
            a_acc   = s_acc;
            a_wdata = s_wdata;
        end else begin
            a_addr  = addr_q;
            a_w_rb  = w_rb_q;
            a_acc   = acc_q;
            a_wdata = wdata_q;
        end
    end

    always_comb begin
        lane = a_addr[1:0];
`ifdef BUS_SRAM_MISALIGN_FAULT_EN
        mis = ((a_acc == 2'd1) && lane[0]) ||
              ((a_acc == 2'd2) && (lane != 2'd0));
        eff_lane = lane;
`else
        mis = 1'b0;
        case (a_acc)
            2'd1:    eff_lane = {lane[1], 1'b0};
            2'd2:    eff_lane = 2'd0;
            default: eff_lane = lane;
        endcase
`endif
        acc_fault = (a_acc == 2'd3) || mis;
        case (a_acc)
            2'd0:    be = 4'b0001 << eff_lane;
            2'd1:    be = 4'b0011 << eff_lane;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        wd_shift = a_wdata << {eff_lane, 3'b000};
        rd_shift = mem[a_addr[SPAN-1:2]] >> {eff_lane, 3'b000};
        case (a_acc)
            2'd0:    rd_val = {24'd0, rd_shift[7:0]};
            2'd1:    rd_val = {16'd0, rd_shift[15:0]};
            default: rd_val = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        w_rb_d  = w_rb_q;
        acc_d   = acc_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_req) begin
                    addr_d  = s_addr;
                    w_rb_d  = s_w_rb;
                    acc_d   = s_acc;
                    wdata_d = s_wdata;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        resp_d  = commit;
        fault_d = commit && acc_fault;
        rdata_d = (commit && !a_w_rb && !acc_fault) ? rd_val : 32'd0;
    end

    assign we = commit && a_w_rb && !acc_fault && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            w_rb_q  <= 1'b0;
            acc_q   <= 2'd0;
            wdata_q <= 32'd0;
            resp_q  <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            w_rb_q  <= w_rb_d;
            acc_q   <= acc_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory contents survive reset; only the lanes selected by be change.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[a_addr[SPAN-1:2]][8*i +: 8] <= wd_shift[8*i +: 8];
                end
            end
        end
    end

    assign s_resp  = resp_q;
    assign s_fault = fault_q;
    assign s_rdata = rdata_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Directed bench for bus_sram_slave: one zero-wait and one three-wait instance.
// Expectations follow BUS_SRAM_MISALIGN_FAULT_EN when it is defined.
module tb_bus_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req3 = 1'b0;
    logic [11:0] addr = '0;
    logic        w_rb = 1'b0;
    logic [1:0]  acc = 2'd0;
    logic [31:0] wdata = '0;
    logic        resp0, fault0, resp3, fault3;
    logic [31:0] rdata0, rdata3;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bus_sram_slave #(.SPAN(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .s_req(req0), .s_addr(addr),
        .s_w_rb(w_rb), .s_acc(acc), .s_wdata(wdata),
        .s_resp(resp0), .s_rdata(rdata0), .s_fault(fault0)
    );

    bus_sram_slave #(.SPAN(12), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .s_req(req3), .s_addr(addr),
        .s_w_rb(w_rb), .s_acc(acc), .s_wdata(wdata),
        .s_resp(resp3), .s_rdata(rdata3), .s_fault(fault3)
    );

    typedef struct {
        string       name;
        bit          sel;
        bit          w;
        logic [1:0]  acc;
        logic [11:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] rd;
        logic        flt;
        bit          chk_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic cur_resp(input bit sel);
        return sel ? resp3 : resp0;
    endfunction

    // Entered and left at #1 after a rising edge; the next request may follow immediately.
    task automatic do_acc(input bit sel, input bit w, input logic [1:0] a,
                          input logic [11:0] ad, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd,
                          output logic flt, output logic stay);
        addr  = ad;
        w_rb  = w;
        acc   = a;
        wdata = wd;
        if (sel) req3 = 1'b1;
        else     req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        req3 = 1'b0;
        lat  = 1;
        while (!cur_resp(sel) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cur_resp(sel)) lat = -1;
        rd  = sel ? rdata3 : rdata0;
        flt = sel ? fault3 : fault0;
        @(posedge clk); #1;
        stay = cur_resp(sel);
    endtask

    function automatic vec_t mk(input string n, input bit s, input bit w,
                                input logic [1:0] a, input logic [11:0] ad,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic flt, input bit cr);
        vec_t v;
        v.name = n; v.sel = s; v.w = w; v.acc = a; v.addr = ad;
        v.wd = wd; v.lat = s ? 4 : 1; v.rd = rd; v.flt = flt; v.chk_rd = cr;
        return v;
    endfunction

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        flt, stay, seen;

        vecs.push_back(mk("w_word10", 0, 1, 2, 12'h010, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk("r_word10", 0, 0, 2, 12'h010, 0, 32'hDEADBEEF, 0, 1));
        vecs.push_back(mk("w_byte13", 0, 1, 0, 12'h013, 32'h000000AA, 0, 0, 0));
        vecs.push_back(mk("r_word10b", 0, 0, 2, 12'h010, 0, 32'hAAADBEEF, 0, 1));
        vecs.push_back(mk("r_byte11", 0, 0, 0, 12'h011, 0, 32'h000000BE, 0, 1));
        vecs.push_back(mk("r_half12", 0, 0, 1, 12'h012, 0, 32'h0000AAAD, 0, 1));
        vecs.push_back(mk("r_acc3", 0, 0, 3, 12'h010, 0, 32'h0, 1, 1));
        vecs.push_back(mk("w_acc3", 0, 1, 3, 12'h010, 32'h11111111, 32'h0, 1, 1));
        vecs.push_back(mk("r_after_acc3", 0, 0, 2, 12'h010, 0, 32'hAAADBEEF, 0, 1));
        vecs.push_back(mk("w_word14", 0, 1, 2, 12'h014, 32'h01020304, 0, 0, 0));
        vecs.push_back(mk("w_half16", 0, 1, 1, 12'h016, 32'h12345678, 0, 0, 0));
        vecs.push_back(mk("r_word14", 0, 0, 2, 12'h014, 0, 32'h56780304, 0, 1));
        vecs.push_back(mk("r_half14", 0, 0, 1, 12'h014, 0, 32'h00000304, 0, 1));
        vecs.push_back(mk("r_byte17", 0, 0, 0, 12'h017, 0, 32'h00000056, 0, 1));
`ifdef BUS_SRAM_MISALIGN_FAULT_EN
        vecs.push_back(mk("w_mis12", 0, 1, 2, 12'h012, 32'hFFFFFFFF, 32'h0, 1, 1));
        vecs.push_back(mk("r_half13", 0, 0, 1, 12'h013, 0, 32'h0, 1, 1));
`else
        vecs.push_back(mk("r_mis12", 0, 0, 2, 12'h012, 0, 32'hAAADBEEF, 0, 1));
        vecs.push_back(mk("r_half13", 0, 0, 1, 12'h013, 0, 32'h0000AAAD, 0, 1));
`endif
        vecs.push_back(mk("r_word10c", 0, 0, 2, 12'h010, 0, 32'hAAADBEEF, 0, 1));
        vecs.push_back(mk("w3_word10", 1, 1, 2, 12'h010, 32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk("w3_byte13", 1, 1, 0, 12'h013, 32'h000000AA, 0, 0, 0));
        vecs.push_back(mk("r3_half12", 1, 0, 1, 12'h012, 0, 32'h0000AAAD, 0, 1));
        vecs.push_back(mk("r3_acc3", 1, 0, 3, 12'h010, 0, 32'h0, 1, 1));

        // Reset, with a request coincident with the last reset edge.
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        chk("rst_resp0", 32'(resp0), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_fault3", 32'(fault3), 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= resp0;
        end
        chk("req_in_rst_dropped", 32'(seen), 0);

        foreach (vecs[i]) begin
            do_acc(vecs[i].sel, vecs[i].w, vecs[i].acc, vecs[i].addr,
                   vecs[i].wd, lat, rd, flt, stay);
            chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_fault"}, 32'(flt), 32'(vecs[i].flt));
            chk({vecs[i].name, "_pulse"}, 32'(stay), 0);
            if (vecs[i].chk_rd) chk({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
        end

        // Reset in the middle of a waited write aborts it.
        addr  = 12'h010;
        w_rb  = 1'b1;
        acc   = 2'd2;
        wdata = 32'h55555555;
        req3  = 1'b1;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_resp3", 32'(resp3), 0);
        chk("abort_fault3", 32'(fault3), 0);
        chk("abort_rdata3", rdata3, 0);
        chk("abort_resp0", 32'(resp0), 0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= resp3;
        end
        chk("abort_no_resp", 32'(seen), 0);
        do_acc(1, 0, 2, 12'h010, 0, lat, rd, flt, stay);
        chk("abort_old_lat", 32'(lat), 4);
        chk("abort_old_data", rd, 32'hAAADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_sram_slave.md
# bus_sram_slave

Bus responder for the femto data/instruction bus. It terminates one slave port of the bus interconnect, either as a TCM or as an SRAM window. It decodes `req/addr/w_rb/acc/wdata` into byte-lane accesses on an internal word-organised memory and returns `resp/rdata/fault` after a programmable number of wait states. It is the slave-side counterpart of the interconnect's per-slave request outputs.

## Interface
- `SPAN`, 12: byte-address width; memory depth is 2^(SPAN-2) 32-bit words.
- `WAIT_CYCLES`, 0: extra cycles inserted between request and response (0..15).
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous reset, active-high.
- `s_req` in 1: single-cycle request strobe.
- `s_addr` in SPAN: byte address.
- `s_w_rb` in 1: 1 = write, 0 = read.
- `s_acc` in `$clog2(BUS_ACC_CNT)` (2): access size; 0 = byte, 1 = half, 2 = word, 3 = reserved.
- `s_wdata` in `BUS_WIDTH` (32): write data, right-aligned.
- `s_resp` out 1: single-cycle response strobe.
- `s_rdata` out 32: read data, right-aligned and zero-extended; valid only while `s_resp`=1.
- `s_fault` out 1: access error; asserted only together with `s_resp`.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE with `s_req`=1:
  - Latch addr, w_rb, acc and wdata.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES`>0, else go to RESP.
- WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 1.
- RESP: `s_resp`=1 for exactly one cycle, then return to IDLE.
- `s_req` is ignored outside IDLE. The master must not issue a new request before `s_resp`. Back-to-back operation means a new `s_req` may arrive in the cycle after RESP.
- Fault conditions:
  - `acc`=3.
  - Misaligned access, only with the macro below: half with addr[0]=1, or word with addr[1:0]≠0.
- On a fault:
  - No memory write.
  - `s_rdata`=0.
  - `s_fault`=1 with `s_resp`, at the same latency as a normal access.
- Write lane mapping, using lane = addr[1:0]:
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - Half: wdata[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
  - Untouched lanes keep their value.
- Read: the selected word is shifted right by 8·addr[1:0], then masked to 8, 16 or 32 bits.
- Word index is addr[SPAN-1:2]. Addresses wrap within 2^SPAN bytes; the upper bits are already stripped by the interconnect.
- The write is committed on the clock edge that enters RESP. The read uses memory contents as of that same edge, so a read always sees every previously responded write.

## Timing
- Request sampled at edge N gives `s_resp` high in cycle N+1+`WAIT_CYCLES`.
- Throughput is one access per 2+`WAIT_CYCLES` cycles.
- `s_resp`, `s_fault` and `s_rdata` are registered outputs with no combinational path from inputs.
- Reset values: `s_resp`=0, `s_fault`=0, `s_rdata`=0, FSM=IDLE, counter=0. Memory contents are not reset.
- Reset in WAIT or RESP aborts the access:
  - No response is generated.
  - A pending write is not committed if reset is asserted at or before the commit edge.
- `s_req` coincident with `rst` is dropped.

## Configuration
- Macro: `BUS_SRAM_MISALIGN_FAULT_EN`.
- Defined: misaligned half/word accesses fault as described above.
- Undefined:
  - addr[0] is forced to 0 for half; addr[1:0] is forced to 0 for word.
  - The access proceeds aligned with no fault.
  - Only `acc`=3 faults.

## Test plan
- WAIT_CYCLES=0: word write 0xDEADBEEF @0x010, then word read @0x010.
  - `s_resp` one cycle after each `s_req`.
  - Read returns 0xDEADBEEF, `s_fault`=0.
- Byte write 0xAA @0x013, then word read @0x010.
  - Returns 0xAAADBEEF.
  - Byte read @0x011 returns 0x000000BE.
- WAIT_CYCLES=3: half read @0x012.
  - `s_resp` exactly 4 cycles after `s_req`.
  - Returns 0x0000AAAD.
- Macro defined: word write @0x012.
  - `s_resp`=`s_fault`=1, `s_rdata`=0.
  - Word @0x010 is unchanged.
- Macro undefined: word read @0x012 returns the word @0x010, `s_fault`=0.
- `acc`=3 gives a fault under both builds.
- WAIT_CYCLES=3: word write, with `rst` asserted during WAIT.
  - No `s_resp`.
  - A subsequent read shows the old data.
  - All outputs are 0 in the cycle after reset.
